// File: rtl/fifo_port_arbiter_pkg.sv
// Shared encodings for the FIFO port arbiter: controller states and
// requester indices used by the round-robin grant logic.
package fifo_port_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    TURN,
    CLR
  } state_e;

  typedef enum logic [1:0] {
    REQ_W0 = 2'd0,
    REQ_W1 = 2'd1,
    REQ_R  = 2'd2
  } req_idx_e;

  localparam int unsigned NUM_REQ = 3;

  function automatic req_idx_e next_idx(input req_idx_e i);
    case (i)
      REQ_W0:  return REQ_W1;
      REQ_W1:  return REQ_R;
      default: return REQ_W0;
    endcase
  endfunction

endpackage

// File: rtl/fifo_port_arbiter_rr_arbiter3.sv
// Three-way round-robin arbiter; ptr_q names the requester with highest
// priority and moves past the winner only when the grant is committed.
module rr_arbiter3
  import fifo_port_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic [2:0] req,
  input  logic     commit,
  output logic     gnt_valid,
  output req_idx_e gnt_idx
);

  req_idx_e ptr_q;
  req_idx_e ptr_d;
  req_idx_e cand;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = ptr_q;
    cand      = ptr_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (commit && gnt_valid) begin
      ptr_d = next_idx(gnt_idx);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= REQ_W0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Shares a single-port bidirectional FIFO between two writers and one reader,
// tracking occupancy, inserting a read->write bus turnaround and handling flush.
module fifo_port_arbiter
  import fifo_port_arbiter_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CW    = 11
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          W0_REQ,
  input  logic [N-1:0]  W0_DATA,
  output logic          W0_ACK,
  input  logic          W1_REQ,
  input  logic [N-1:0]  W1_DATA,
  output logic          W1_ACK,
  input  logic          R_REQ,
  output logic          R_ACK,
  output logic [N-1:0]  R_DATA,
  output logic          R_VALID,
  input  logic          FLUSH,
  output logic          FIFO_EN,
  output logic          FIFO_RW,
  output logic          FIFO_RST,
  inout  wire  [N-1:0]  FIFO_DATA,
  input  logic          FIFO_EMPTY,
  input  logic          FIFO_FULL,
  output logic [CW-1:0] COUNT,
  output logic          ERR
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_e        state_q,    state_d;
  logic [CW-1:0] count_q,    count_d;
  logic          w0_ack_q,   w0_ack_d;
  logic          w1_ack_q,   w1_ack_d;
  logic          r_ack_q,    r_ack_d;
  logic          r_valid_q,  r_valid_d;
  logic [N-1:0]  r_data_q,   r_data_d;
  logic          fifo_en_q,  fifo_en_d;
  logic          fifo_rw_q,  fifo_rw_d;
  logic          bus_oe_q,   bus_oe_d;
  logic [N-1:0]  bus_data_q, bus_data_d;
  logic          clr_q,      clr_d;
  logic          err_q,      err_d;

  logic [CW-1:0] count_eff;
  logic [2:0]    elig;
  logic          commit;
  logic          gnt_valid;
  req_idx_e      gnt_idx;
  logic          flag_bad;

  rr_arbiter3 u_rr (
    .clk       (CLK),
    .rst_n     (RESET),
    .req       (elig),
    .commit    (commit),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  // Eligibility uses the occupancy after this edge's update; a CLR cycle
  // ending now has already emptied the FIFO.
  always_comb begin
    count_eff    = (state_q == CLR) ? '0 : count_q;
    elig         = '0;
    elig[REQ_W0] = W0_REQ && !w0_ack_q && (count_eff < DEPTH_C);
    elig[REQ_W1] = W1_REQ && !w1_ack_q && (count_eff < DEPTH_C);
    elig[REQ_R]  = R_REQ  && !r_ack_q  && (count_eff != '0);
  end

  always_comb begin
    flag_bad = (FIFO_EMPTY != (count_q == '0)) ||
               (FIFO_FULL  != (count_q == DEPTH_C));
  end

  always_comb begin
    state_d    = IDLE;
    count_d    = count_eff;
    w0_ack_d   = 1'b0;
    w1_ack_d   = 1'b0;
    r_ack_d    = 1'b0;
    fifo_en_d  = 1'b0;
    fifo_rw_d  = 1'b0;
    bus_oe_d   = 1'b0;
    bus_data_d = bus_data_q;
    clr_d      = 1'b0;
    commit     = 1'b0;
    r_valid_d  = (state_q == RD);
    r_data_d   = (state_q == RD) ? FIFO_DATA : r_data_q;
    err_d      = err_q || ((state_q != CLR) && flag_bad);

    if (FLUSH) begin
      state_d = CLR;
      clr_d   = 1'b1;
    end else if (gnt_valid) begin
      // A write right after a read first spends one idle cycle on the bus;
      // the grant is not committed so arbitration is redone after TURN.
      if ((gnt_idx != REQ_R) && (state_q == RD)) begin
        state_d = TURN;
      end else begin
        commit    = 1'b1;
        fifo_en_d = 1'b1;
        case (gnt_idx)
          REQ_W0: begin
            state_d    = WR;
            w0_ack_d   = 1'b1;
            fifo_rw_d  = 1'b1;
            bus_oe_d   = 1'b1;
            bus_data_d = W0_DATA;
            count_d    = count_eff + CW'(1);
          end
          REQ_W1: begin
            state_d    = WR;
            w1_ack_d   = 1'b1;
            fifo_rw_d  = 1'b1;
            bus_oe_d   = 1'b1;
            bus_data_d = W1_DATA;
            count_d    = count_eff + CW'(1);
          end
          default: begin
            state_d = RD;
            r_ack_d = 1'b1;
            count_d = count_eff - CW'(1);
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= IDLE;
      count_q    <= '0;
      w0_ack_q   <= 1'b0;
      w1_ack_q   <= 1'b0;
      r_ack_q    <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      fifo_en_q  <= 1'b0;
      fifo_rw_q  <= 1'b0;
      bus_oe_q   <= 1'b0;
      bus_data_q <= '0;
      clr_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      w0_ack_q   <= w0_ack_d;
      w1_ack_q   <= w1_ack_d;
      r_ack_q    <= r_ack_d;
      r_valid_q  <= r_valid_d;
      r_data_q   <= r_data_d;
      fifo_en_q  <= fifo_en_d;
      fifo_rw_q  <= fifo_rw_d;
      bus_oe_q   <= bus_oe_d;
      bus_data_q <= bus_data_d;
      clr_q      <= clr_d;
      err_q      <= err_d;
    end
  end

  assign FIFO_DATA = bus_oe_q ? bus_data_q : 'z;
  assign FIFO_RST  = !RESET || clr_q;
  assign FIFO_EN   = fifo_en_q;
  assign FIFO_RW   = fifo_rw_q;
  assign W0_ACK    = w0_ack_q;
  assign W1_ACK    = w1_ack_q;
  assign R_ACK     = r_ack_q;
  assign R_VALID   = r_valid_q;
  assign R_DATA    = r_data_q;
  assign COUNT     = count_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Directed bench for fifo_port_arbiter with a behavioural single-port FIFO
// whose flags reflect the operation currently being performed.
module tb_fifo_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        w0_req, w1_req, r_req, flush;
  logic [7:0]  w0_data, w1_data;
  logic        w0_ack, w1_ack, r_ack, r_valid;
  logic [7:0]  r_data;
  logic        fifo_en, fifo_rw, fifo_rst;
  tri1  [7:0]  fifo_data;
  logic        fifo_empty, fifo_full;
  logic [10:0] count;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  mem [0:1023];
  logic [9:0]  wp, rp;
  logic [10:0] occ;
  int          occ_la;
  logic        force_empty = 1'b0;

  always #5 clk = ~clk;

  fifo_port_arbiter #(.N(8), .DEPTH(1024), .CW(11)) dut (
    .CLK        (clk),
    .RESET      (reset_n),
    .W0_REQ     (w0_req),
    .W0_DATA    (w0_data),
    .W0_ACK     (w0_ack),
    .W1_REQ     (w1_req),
    .W1_DATA    (w1_data),
    .W1_ACK     (w1_ack),
    .R_REQ      (r_req),
    .R_ACK      (r_ack),
    .R_DATA     (r_data),
    .R_VALID    (r_valid),
    .FLUSH      (flush),
    .FIFO_EN    (fifo_en),
    .FIFO_RW    (fifo_rw),
    .FIFO_RST   (fifo_rst),
    .FIFO_DATA  (fifo_data),
    .FIFO_EMPTY (fifo_empty),
    .FIFO_FULL  (fifo_full),
    .COUNT      (count),
    .ERR        (err)
  );

  assign fifo_data = (fifo_en && !fifo_rw) ? mem[rp] : 'z;

  always @(posedge clk) begin
    if (fifo_rst) begin
      wp  <= '0;
      rp  <= '0;
      occ <= '0;
    end else if (fifo_en && fifo_rw && occ < 11'd1024) begin
      mem[wp] <= fifo_data;
      wp      <= wp + 10'd1;
      occ     <= occ + 11'd1;
    end else if (fifo_en && !fifo_rw && occ != 11'd0) begin
      rp  <= rp + 10'd1;
      occ <= occ - 11'd1;
    end
  end

  always_comb begin
    occ_la = int'(occ);
    if (fifo_en && fifo_rw) occ_la = occ_la + 1;
    if (fifo_en && !fifo_rw) occ_la = occ_la - 1;
    fifo_empty = force_empty || (occ_la == 0);
    fifo_full  = (occ_la == 1024);
  end

  task automatic apply_reset();
    reset_n = 1'b0;
    w0_req = 1'b0; w1_req = 1'b0; r_req = 1'b0; flush = 1'b0;
    w0_data = '0; w1_data = '0;
    force_empty = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    w0_req = 1'b0; w1_req = 1'b0; r_req = 1'b0; flush = 1'b0;
    w0_data = '0; w1_data = '0;
    repeat (2) @(negedge clk);
    vectors++; if (fifo_rst !== 1'b1) begin miscompares++; $display("FAIL reset_fifo_rst got %b want 1", fifo_rst); end
    vectors++; if (count !== 11'd0) begin miscompares++; $display("FAIL reset_count got %0d want 0", count); end
    vectors++; if ({w0_ack, w1_ack, r_ack, r_valid} !== 4'b0) begin miscompares++; $display("FAIL reset_acks got %b want 0000", {w0_ack, w1_ack, r_ack, r_valid}); end
    vectors++; if (r_data !== 8'h00) begin miscompares++; $display("FAIL reset_r_data got %h want 00", r_data); end
    vectors++; if ({fifo_en, fifo_rw} !== 2'b00) begin miscompares++; $display("FAIL reset_en_rw got %b want 00", {fifo_en, fifo_rw}); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (fifo_data !== 8'hFF) begin miscompares++; $display("FAIL reset_bus_released got %h want FF", fifo_data); end
    reset_n = 1'b1;
    #1;
    vectors++; if (fifo_rst !== 1'b0) begin miscompares++; $display("FAIL reset_release_fifo_rst got %b want 0", fifo_rst); end
    @(negedge clk);
  endtask

  task automatic test_single_writes();
    logic [7:0] wd [0:2];
    int idx = 0;
    logic exp_ack;
    wd[0] = 8'h11; wd[1] = 8'h22; wd[2] = 8'h33;
    apply_reset();
    w0_req = 1'b1; w0_data = wd[0];
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_ack = (c % 2 == 1);
      vectors++; if (w0_ack !== exp_ack) begin miscompares++; $display("FAIL wr_w0_ack cycle %0d got %b want %b", c, w0_ack, exp_ack); end
      if (exp_ack) begin
        vectors++; if (fifo_data !== wd[idx]) begin miscompares++; $display("FAIL wr_bus cycle %0d got %h want %h", c, fifo_data, wd[idx]); end
        idx++;
        vectors++; if (count !== 11'(idx)) begin miscompares++; $display("FAIL wr_count cycle %0d got %0d want %0d", c, count, idx); end
        if (idx == 3) w0_req = 1'b0; else w0_data = wd[idx];
      end
    end
    vectors++; if (count !== 11'd3) begin miscompares++; $display("FAIL wr_final_count got %0d want 3", count); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL wr_err got %b want 0", err); end
  endtask

  task automatic test_alternate();
    logic exp0, exp1;
    apply_reset();
    w0_req = 1'b1; w0_data = 8'hA0;
    w1_req = 1'b1; w1_data = 8'hB0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      exp0 = (c % 2 == 1);
      exp1 = (c % 2 == 0);
      vectors++; if ({w0_ack, w1_ack} !== {exp0, exp1}) begin miscompares++; $display("FAIL alt_acks cycle %0d got %b want %b", c, {w0_ack, w1_ack}, {exp0, exp1}); end
      vectors++; if (fifo_data !== (exp0 ? 8'hA0 : 8'hB0)) begin miscompares++; $display("FAIL alt_bus cycle %0d got %h want %h", c, fifo_data, exp0 ? 8'hA0 : 8'hB0); end
    end
    w0_req = 1'b0; w1_req = 1'b0;
    @(negedge clk);
    vectors++; if ({w0_ack, w1_ack} !== 2'b00) begin miscompares++; $display("FAIL alt_idle_acks got %b want 00", {w0_ack, w1_ack}); end
    vectors++; if (count !== 11'd4) begin miscompares++; $display("FAIL alt_count got %0d want 4", count); end
  endtask

  task automatic test_read();
    apply_reset();
    w0_req = 1'b1; w0_data = 8'h11;
    @(negedge clk);
    vectors++; if (w0_ack !== 1'b1) begin miscompares++; $display("FAIL rd_setup_ack1 got %b want 1", w0_ack); end
    w0_data = 8'h22;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (w0_ack !== 1'b1) begin miscompares++; $display("FAIL rd_setup_ack2 got %b want 1", w0_ack); end
    w0_req = 1'b0;
    @(negedge clk);
    r_req = 1'b1;
    @(negedge clk);
    vectors++; if ({r_ack, fifo_en, fifo_rw} !== 3'b110) begin miscompares++; $display("FAIL rd1_ack_en_rw got %b want 110", {r_ack, fifo_en, fifo_rw}); end
    vectors++; if (count !== 11'd1) begin miscompares++; $display("FAIL rd1_count got %0d want 1", count); end
    @(negedge clk);
    vectors++; if ({r_valid, r_ack} !== 2'b10) begin miscompares++; $display("FAIL rd1_valid got %b want 10", {r_valid, r_ack}); end
    vectors++; if (r_data !== 8'h11) begin miscompares++; $display("FAIL rd1_data got %h want 11", r_data); end
    @(negedge clk);
    vectors++; if (r_ack !== 1'b1) begin miscompares++; $display("FAIL rd2_ack got %b want 1", r_ack); end
    vectors++; if (count !== 11'd0) begin miscompares++; $display("FAIL rd2_count got %0d want 0", count); end
    r_req = 1'b0;
    @(negedge clk);
    vectors++; if (r_valid !== 1'b1) begin miscompares++; $display("FAIL rd2_valid got %b want 1", r_valid); end
    vectors++; if (r_data !== 8'h22) begin miscompares++; $display("FAIL rd2_data got %h want 22", r_data); end
    r_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if ({r_ack, fifo_en} !== 2'b00) begin miscompares++; $display("FAIL rd_empty_no_ack cycle %0d got %b want 00", c, {r_ack, fifo_en}); end
    end
    r_req = 1'b0;
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rd_err got %b want 0", err); end
  endtask

  task automatic test_turnaround();
    apply_reset();
    w0_req = 1'b1; w0_data = 8'h11;
    @(negedge clk);
    vectors++; if (w0_ack !== 1'b1) begin miscompares++; $display("FAIL ta_setup_ack got %b want 1", w0_ack); end
    w0_req = 1'b0;
    @(negedge clk);
    r_req = 1'b1;
    @(negedge clk);
    vectors++; if (r_ack !== 1'b1) begin miscompares++; $display("FAIL ta_r_ack got %b want 1", r_ack); end
    r_req = 1'b0; w0_req = 1'b1; w0_data = 8'h55;
    @(negedge clk);
    vectors++; if ({fifo_en, w0_ack} !== 2'b00) begin miscompares++; $display("FAIL ta_turn_en_ack got %b want 00", {fifo_en, w0_ack}); end
    vectors++; if (fifo_data !== 8'hFF) begin miscompares++; $display("FAIL ta_turn_bus got %h want FF", fifo_data); end
    vectors++; if ({r_valid, r_data} !== {1'b1, 8'h11}) begin miscompares++; $display("FAIL ta_read_data got %b/%h want 1/11", r_valid, r_data); end
    @(negedge clk);
    vectors++; if (w0_ack !== 1'b1) begin miscompares++; $display("FAIL ta_w0_ack got %b want 1", w0_ack); end
    vectors++; if (fifo_data !== 8'h55) begin miscompares++; $display("FAIL ta_w0_bus got %h want 55", fifo_data); end
    vectors++; if (count !== 11'd1) begin miscompares++; $display("FAIL ta_count got %0d want 1", count); end
    w0_req = 1'b0; r_req = 1'b1;
    @(negedge clk);
    vectors++; if ({r_ack, fifo_en, fifo_rw} !== 3'b110) begin miscompares++; $display("FAIL ta_wr_rd_nogap got %b want 110", {r_ack, fifo_en, fifo_rw}); end
    r_req = 1'b0;
    @(negedge clk);
    vectors++; if ({r_valid, r_data} !== {1'b1, 8'h55}) begin miscompares++; $display("FAIL ta_rd_back got %b/%h want 1/55", r_valid, r_data); end
  endtask

  task automatic test_full();
    int acks = 0;
    apply_reset();
    w0_req = 1'b1; w0_data = 8'h3C;
    w1_req = 1'b1; w1_data = 8'hC3;
    for (int c = 0; c < 1100 && acks < 1024; c++) begin
      @(negedge clk);
      vectors++; if (w0_ack && w1_ack) begin miscompares++; $display("FAIL full_two_acks cycle %0d got 11 want at most one", c); end
      acks += int'(w0_ack) + int'(w1_ack);
    end
    vectors++; if (acks != 1024) begin miscompares++; $display("FAIL full_ack_total got %0d want 1024", acks); end
    w0_req = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      vectors++; if ({w1_ack, fifo_en} !== 2'b00) begin miscompares++; $display("FAIL full_w1_blocked cycle %0d got %b want 00", c, {w1_ack, fifo_en}); end
    end
    w1_req = 1'b0;
    vectors++; if (count !== 11'd1024) begin miscompares++; $display("FAIL full_count got %0d want 1024", count); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL full_err got %b want 0", err); end
  endtask

  task automatic test_flush();
    apply_reset();
    w0_req = 1'b1; w0_data = 8'h01;
    w1_req = 1'b1; w1_data = 8'h02;
    repeat (5) @(negedge clk);
    vectors++; if ({w0_ack, count} !== {1'b1, 11'd5}) begin miscompares++; $display("FAIL fl_setup got %b/%0d want 1/5", w0_ack, count); end
    w1_req = 1'b0; w0_data = 8'h77; flush = 1'b1;
    @(negedge clk);
    vectors++; if (fifo_rst !== 1'b1) begin miscompares++; $display("FAIL fl_clr_rst got %b want 1", fifo_rst); end
    vectors++; if ({fifo_en, w0_ack, w1_ack, r_ack} !== 4'b0) begin miscompares++; $display("FAIL fl_clr_quiet got %b want 0000", {fifo_en, w0_ack, w1_ack, r_ack}); end
    flush = 1'b0;
    @(negedge clk);
    vectors++; if (fifo_rst !== 1'b0) begin miscompares++; $display("FAIL fl_rst_pulse got %b want 0", fifo_rst); end
    vectors++; if ({w0_ack, fifo_data} !== {1'b1, 8'h77}) begin miscompares++; $display("FAIL fl_w0_after_clr got %b/%h want 1/77", w0_ack, fifo_data); end
    vectors++; if (count !== 11'd1) begin miscompares++; $display("FAIL fl_count got %0d want 1", count); end
    w0_req = 1'b0;
    @(negedge clk);
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL fl_err got %b want 0", err); end
  endtask

  task automatic test_err();
    apply_reset();
    w0_req = 1'b1; w0_data = 8'h5A;
    w1_req = 1'b1; w1_data = 8'hA5;
    repeat (5) @(negedge clk);
    w0_req = 1'b0; w1_req = 1'b0;
    @(negedge clk);
    vectors++; if ({err, count} !== {1'b0, 11'd5}) begin miscompares++; $display("FAIL err_pre got %b/%0d want 0/5", err, count); end
    force_empty = 1'b1;
    @(negedge clk);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_set got %b want 1", err); end
    force_empty = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %b want 1", err); end
  endtask

  task automatic test_async_abort();
    apply_reset();
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL abort_err_cleared got %b want 0", err); end
    w0_req = 1'b1; w0_data = 8'h99;
    @(posedge clk);
    #1;
    vectors++; if (w0_ack !== 1'b1) begin miscompares++; $display("FAIL abort_pre_ack got %b want 1", w0_ack); end
    reset_n = 1'b0;
    #1;
    vectors++; if ({w0_ack, fifo_en, fifo_rst} !== 3'b001) begin miscompares++; $display("FAIL abort_async got %b want 001", {w0_ack, fifo_en, fifo_rst}); end
    vectors++; if (count !== 11'd0) begin miscompares++; $display("FAIL abort_count got %0d want 0", count); end
    w0_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++; if (w0_ack !== 1'b0) begin miscompares++; $display("FAIL abort_no_ack got %b want 0", w0_ack); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_writes();
    test_alternate();
    test_read();
    test_turnaround();
    test_full();
    test_flush();
    test_err();
    test_async_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
